data_memory_ctrl: RTL and testbench

//  MEM-stage data memory: the responder that drives BUSYWAIT into the IF/ID, ID/EX, EX/MEM and MEM/WB regs.

---
 rtl/data_memory_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_data_memory_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/data_memory_ctrl.sv
// MEM-stage data memory controller.
// Decodes the pipeline's 4-bit access code and performs byte/half/word loads
// and stores against an internal word array with a fixed multi-cycle latency.
// BUSYWAIT freezes the pipeline registers until the access reaches DONE.
module data_memory_ctrl #(
    parameter int LATENCY = 4,
    parameter int ADDR_W  = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITE_DATA,
    input  logic [3:0]  READ_WRITE,
    output logic [31:0] READ_DATA,
    output logic        BUSYWAIT,
    output logic        ADDR_MISALIGNED
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(LATENCY - 1);
    localparam int         DEPTH    = 1 << ADDR_W;

    // Access sizes as carried in the decoded request
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [31:0]        mem_q [0:DEPTH-1];

    logic               is_load;
    logic               is_store;
    logic [1:0]         acc_size;
    logic               acc_unsigned;
    logic               req;
    logic               misaligned;
    logic               complete;
    logic [ADDR_W-1:0]  word_idx;
    logic [31:0]        cur_word;
    logic               mem_we;
    logic [31:0]        mem_wdata;

    // Upper address bits fall outside the array and wrap away
    logic               unused_addr_bits;
    assign unused_addr_bits = ^ADDRESS[31:ADDR_W+2];

    // Shift the addressed byte/half down to bit 0 and sign- or zero-extend it
    function automatic logic [31:0] load_extend(
        input logic [31:0] word,
        input logic [1:0]  off,
        input logic [1:0]  size,
        input logic        uns
    );
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (size)
            SZ_BYTE: load_extend = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            SZ_HALF: load_extend = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: load_extend = word;
        endcase
    endfunction

    // Merge store data into the old word on the addressed byte lanes only
    function automatic logic [31:0] store_merge(
        input logic [31:0] old_word,
        input logic [31:0] wdata,
        input logic [1:0]  off,
        input logic [1:0]  size
    );
        logic [3:0]  be;
        logic [31:0] mask;
        logic [31:0] data_sh;
        case (size)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        mask    = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        data_sh = wdata << {off, 3'b000};
        store_merge = (old_word & ~mask) | (data_sh & mask);
    endfunction

    // Decode the access code into direction, size and extension
    always_comb begin
        is_load      = 1'b0;
        is_store     = 1'b0;
        acc_size     = SZ_BYTE;
        acc_unsigned = 1'b0;
        case (READ_WRITE)
            4'b1000: begin is_load  = 1'b1; acc_size = SZ_BYTE; end
            4'b1001: begin is_load  = 1'b1; acc_size = SZ_HALF; end
            4'b1010: begin is_load  = 1'b1; acc_size = SZ_WORD; end
            4'b1100: begin is_load  = 1'b1; acc_size = SZ_BYTE; acc_unsigned = 1'b1; end
            4'b1101: begin is_load  = 1'b1; acc_size = SZ_HALF; acc_unsigned = 1'b1; end
            4'b0100: begin is_store = 1'b1; acc_size = SZ_BYTE; end
            4'b0101: begin is_store = 1'b1; acc_size = SZ_HALF; end
            4'b0110: begin is_store = 1'b1; acc_size = SZ_WORD; end
            default: ;
        endcase
        req        = is_load | is_store;
        misaligned = req & (((acc_size == SZ_HALF) & ADDRESS[0]) |
                            ((acc_size == SZ_WORD) & (ADDRESS[1:0] != 2'b00)));
        word_idx   = ADDRESS[ADDR_W+1:2];
        complete   = (state_q == S_ACCESS) && (cnt_q == CNT_LAST);
    end

    // State and counter registers; reset wins over any in-flight access
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: aligned request starts ACCESS, counter times the latency
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req && !misaligned) begin
                    state_d = S_ACCESS;
                    cnt_d   = 4'd0;
                end
            end
            S_ACCESS: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // The request still visible here is the one just completed
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Outputs: stall from the request's first cycle until DONE
    always_comb begin
        BUSYWAIT        = 1'b0;
        ADDR_MISALIGNED = 1'b0;
        case (state_q)
            S_IDLE: begin
                BUSYWAIT        = req & ~misaligned;
                ADDR_MISALIGNED = req & misaligned;
            end
            S_ACCESS: BUSYWAIT = 1'b1;
            default:  ;
        endcase
        READ_DATA = rdata_q;
    end

    // Datapath: commit store or capture load on the completing edge
    always_comb begin
        cur_word  = mem_q[word_idx];
        mem_we    = complete & is_store & RESET;
        mem_wdata = store_merge(cur_word, WRITE_DATA, ADDRESS[1:0], acc_size);
        rdata_d   = rdata_q;
        if (complete && is_load) begin
            rdata_d = load_extend(cur_word, ADDRESS[1:0], acc_size, acc_unsigned);
        end
    end

    // Load result register, cleared by reset
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            rdata_q <= 32'h0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    // Storage array; contents survive reset
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem_q[word_idx] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Randomized bench for data_memory_ctrl against a byte-addressed memory model.
module tb_data_memory_ctrl;

    localparam int LATENCY = 4;
    localparam int ADDR_W  = 8;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] ADDRESS;
    logic [31:0] WRITE_DATA;
    logic [3:0]  READ_WRITE;
    logic [31:0] READ_DATA;
    logic        BUSYWAIT;
    logic        ADDR_MISALIGNED;

    int          n_vec = 0;
    int          n_err = 0;

    // Byte-level model of the array: 2**ADDR_W words = 1024 bytes
    logic [7:0]  model_mem [0:1023];
    logic [31:0] exp_rd;

    data_memory_ctrl #(.LATENCY(LATENCY), .ADDR_W(ADDR_W)) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .ADDRESS         (ADDRESS),
        .WRITE_DATA      (WRITE_DATA),
        .READ_WRITE      (READ_WRITE),
        .READ_DATA       (READ_DATA),
        .BUSYWAIT        (BUSYWAIT),
        .ADDR_MISALIGNED (ADDR_MISALIGNED)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Classify an access code: legal, store, size in bytes, unsigned
    task automatic classify(input logic [3:0] code, output bit legal, output bit store,
                            output int nbytes, output bit uns);
        legal = 1'b1; store = 1'b0; nbytes = 1; uns = 1'b0;
        case (code)
            4'b1000: nbytes = 1;
            4'b1001: nbytes = 2;
            4'b1010: nbytes = 4;
            4'b1100: begin nbytes = 1; uns = 1'b1; end
            4'b1101: begin nbytes = 2; uns = 1'b1; end
            4'b0100: begin nbytes = 1; store = 1'b1; end
            4'b0101: begin nbytes = 2; store = 1'b1; end
            4'b0110: begin nbytes = 4; store = 1'b1; end
            default: legal = 1'b0;
        endcase
    endtask

    // One request presented from an IDLE cycle, held until the controller releases it
    task automatic access(input logic [3:0] code, input logic [31:0] addr,
                          input logic [31:0] wd, input string tag);
        bit legal, store, uns, mis;
        int nbytes, n;
        int base;
        longint val;
        classify(code, legal, store, nbytes, uns);
        mis = legal && ((addr % nbytes) != 0);
        @(negedge CLK);
        READ_WRITE = code; ADDRESS = addr; WRITE_DATA = wd;
        #1;
        if (!legal) begin
            chk({tag, "_idle_busy"}, {31'b0, BUSYWAIT}, 32'd0);
            @(negedge CLK); #1;
            chk({tag, "_idle_busy2"}, {31'b0, BUSYWAIT}, 32'd0);
            chk({tag, "_idle_rd"}, READ_DATA, exp_rd);
        end else if (mis) begin
            chk({tag, "_mis_flag"}, {31'b0, ADDR_MISALIGNED}, 32'd1);
            chk({tag, "_mis_busy"}, {31'b0, BUSYWAIT}, 32'd0);
            @(negedge CLK); #1;
            chk({tag, "_mis_busy2"}, {31'b0, BUSYWAIT}, 32'd0);
            chk({tag, "_mis_rd"}, READ_DATA, exp_rd);
        end else begin
            chk({tag, "_mis_flag"}, {31'b0, ADDR_MISALIGNED}, 32'd0);
            n = 0;
            while (BUSYWAIT === 1'b1 && n < 40) begin
                n++;
                @(negedge CLK); #1;
            end
            chk({tag, "_busy_cycles"}, 32'(n), 32'(LATENCY + 1));
            base = int'(addr[9:0]);
            if (store) begin
                for (int i = 0; i < nbytes; i++) model_mem[base + i] = wd[8*i +: 8];
            end else begin
                val = 0;
                for (int i = nbytes - 1; i >= 0; i--) val = (val << 8) | longint'(model_mem[base + i]);
                if (!uns && nbytes < 4 && val[8*nbytes-1]) val = val - (longint'(1) << (8*nbytes));
                exp_rd = val[31:0];
            end
            chk({tag, "_rd"}, READ_DATA, exp_rd);
        end
        READ_WRITE = 4'b0000;
    endtask

    // Store interrupted by reset in its 3rd ACCESS cycle
    task automatic store_with_reset(input logic [31:0] addr, input logic [31:0] wd);
        @(negedge CLK);
        READ_WRITE = 4'b0110; ADDRESS = addr; WRITE_DATA = wd;
        #1;
        chk("rst_mid_busy_start", {31'b0, BUSYWAIT}, 32'd1);
        repeat (3) @(negedge CLK);
        #1;
        chk("rst_mid_busy_access3", {31'b0, BUSYWAIT}, 32'd1);
        RESET = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        READ_WRITE = 4'b0000;
        #1;
        exp_rd = 32'h0;
        chk("rst_mid_rd", READ_DATA, 32'h0);
        chk("rst_mid_busy_after", {31'b0, BUSYWAIT}, 32'd0);
    endtask

    initial begin
        logic [3:0]  codes [0:11];
        logic [31:0] addr;
        codes = '{4'b1000, 4'b1001, 4'b1010, 4'b1100, 4'b1101, 4'b0100,
                  4'b0101, 4'b0110, 4'b0000, 4'b0111, 4'b1111, 4'b0011};

        RESET = 1'b0; READ_WRITE = 4'b0000; ADDRESS = 32'h0; WRITE_DATA = 32'h0;
        exp_rd = 32'h0;
        repeat (2) @(negedge CLK);
        #1;
        chk("reset_rd", READ_DATA, 32'h0);
        chk("reset_busy", {31'b0, BUSYWAIT}, 32'd0);
        chk("reset_mis", {31'b0, ADDR_MISALIGNED}, 32'd0);
        RESET = 1'b1;

        // Give the region used below known contents
        for (int w = 0; w < 16; w++) access(4'b0110, 32'(w * 4), $urandom, "init");

        access(4'b0110, 32'h10, 32'hDEADBEEF, "sw10");
        access(4'b1010, 32'h10, 32'h0, "lw10");
        chk("lw10_const", READ_DATA, 32'hDEADBEEF);
        chk("lw10_done_busy", {31'b0, BUSYWAIT}, 32'd0);

        access(4'b0100, 32'h13, 32'h00000080, "sb13");
        access(4'b1000, 32'h13, 32'h0, "lb13");
        chk("lb13_const", READ_DATA, 32'hFFFFFF80);
        access(4'b1100, 32'h13, 32'h0, "lbu13");
        chk("lbu13_const", READ_DATA, 32'h00000080);
        access(4'b1010, 32'h10, 32'h0, "lw10b");
        chk("lw10b_const", READ_DATA, 32'h80ADBEEF);

        access(4'b0101, 32'h12, 32'h00008001, "sh12");
        access(4'b1001, 32'h12, 32'h0, "lh12");
        chk("lh12_const", READ_DATA, 32'hFFFF8001);
        access(4'b1101, 32'h12, 32'h0, "lhu12");
        chk("lhu12_const", READ_DATA, 32'h00008001);
        access(4'b1001, 32'h11, 32'h0, "lh11");
        chk("lh11_rd_const", READ_DATA, 32'h00008001);

        access(4'b0110, 32'h20, 32'hA5A5_0F0F, "sw20_old");
        store_with_reset(32'h20, 32'h12345678);
        access(4'b1010, 32'h20, 32'h0, "lw20");
        chk("lw20_const", READ_DATA, 32'hA5A5_0F0F);

        access(4'b0110, 32'h400, 32'hCAFEF00D, "sw400");
        access(4'b1010, 32'h000, 32'h0, "lw000");
        chk("wrap_const", READ_DATA, 32'hCAFEF00D);
        access(4'b0111, 32'h000, 32'h11111111, "code0111");
        access(4'b1010, 32'h000, 32'h0, "lw000b");
        chk("code0111_nowrite", READ_DATA, 32'hCAFEF00D);

        for (int t = 0; t < 300; t++) begin
            addr = ($urandom << 10) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            access(codes[$urandom_range(0, 11)], addr, $urandom, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
